// File: rtl/svutest_rsp_sink_if.sv
// Request-payload-response link plus valid/ready drain port.
// master = upstream driver / drain consumer, slave = rsp sink.
interface svutest_rsp_sink_if #(
   parameter int W_PAYLOAD = 32
);
   logic                 req;
   logic [W_PAYLOAD-1:0] req_payload;
   logic                 rsp;
   logic                 out_valid;
   logic [W_PAYLOAD-1:0] out_payload;
   logic                 out_ready;

   modport master (
      output req,
      output req_payload,
      output out_ready,
      input  rsp,
      input  out_valid,
      input  out_payload
   );

   modport slave (
      input  req,
      input  req_payload,
      input  out_ready,
      output rsp,
      output out_valid,
      output out_payload
   );
endinterface

// File: rtl/svutest_rsp_sink.sv
// Buffering sink for a req/rsp link with a valid/ready drain port.
// Define SVUTEST_RSP_SINK_STALL_EN for LFSR-driven random backpressure.
module svutest_rsp_sink #(
   parameter int          W_PAYLOAD = 32,
   parameter int          DEPTH     = 4,
   parameter int          W_COUNT   = 16,
   parameter logic [15:0] SEED      = 16'hACE1
) (
   input  logic                       clk,
   input  logic                       rst,
   svutest_rsp_sink_if.slave          bus,
   input  logic                       i_stall_en,
   input  logic [W_COUNT-1:0]         i_expected_count,
   output logic [W_COUNT-1:0]         o_accepted_count,
   output logic [$clog2(DEPTH):0]     o_level,
   output logic                       o_done
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam logic [PW-1:0]      PTR_ONE = PW'(1);
   localparam logic [W_COUNT-1:0] CNT_ONE = W_COUNT'(1);
   localparam logic [W_COUNT-1:0] CNT_MAX = '1;

   logic [W_PAYLOAD-1:0] r_mem [DEPTH];
   logic [PW-1:0]        r_wptr;
   logic [PW-1:0]        r_rptr;
   logic [W_COUNT-1:0]   r_acc;
   logic                 r_done;
   logic                 w_stall;
   logic                 w_full;
   logic                 w_empty;
   logic                 w_rsp;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_done_cond;

   // Pointers carry one extra wrap bit to tell full from empty.
   assign w_full  = (r_wptr[AW] != r_rptr[AW]) &&
                    (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign w_empty = (r_wptr == r_rptr);

   // Accept depends only on registered state, never on req.
   assign w_rsp  = !w_full && !w_stall;
   assign w_push = bus.req && w_rsp;
   assign w_pop  = !w_empty && bus.out_ready;

   assign bus.rsp         = w_rsp;
   assign bus.out_valid   = !w_empty;
   assign bus.out_payload = r_mem[r_rptr[AW-1:0]];

   assign o_level          = r_wptr - r_rptr;
   assign o_accepted_count = r_acc;
   assign o_done           = r_done;

`ifdef SVUTEST_RSP_SINK_STALL_EN
   logic [15:0] r_lfsr;
   logic        r_stall;
   logic        w_fb;

   // Fibonacci taps 16,14,13,11.
   assign w_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_lfsr  <= SEED;
         r_stall <= 1'b0;
      end else begin
         r_lfsr  <= {r_lfsr[14:0], w_fb};
         r_stall <= i_stall_en && (r_lfsr[1:0] == 2'b00);
      end
   end

   assign w_stall = r_stall;
`else
   logic w_unused;

   assign w_unused = ^{i_stall_en, SEED};
   assign w_stall  = 1'b0;
`endif

   // Payload storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr[AW-1:0]] <= bus.req_payload;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + PTR_ONE;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + PTR_ONE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_acc <= '0;
      end else if (w_push && (r_acc != CNT_MAX)) begin
         r_acc <= r_acc + CNT_ONE;
      end
   end

   assign w_done_cond = (i_expected_count != '0) &&
                        (r_acc >= i_expected_count) &&
                        w_empty;

   // Sticky until reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_done <= 1'b0;
      end else if (w_done_cond) begin
         r_done <= 1'b1;
      end
   end
endmodule

// File: tb/tb_svutest_rsp_sink.sv
// Directed bench for svutest_rsp_sink: ordering, backpressure,
// done flag and asynchronous reset, checked against hand values.
module tb_svutest_rsp_sink;
   logic        clk;
   logic        rst;
   logic        stall_en;
   logic [15:0] expected_count;
   logic [15:0] accepted_count;
   logic [2:0]  level;
   logic        done;
   int          n_chk;
   int          n_pass;

   svutest_rsp_sink_if #(.W_PAYLOAD(32)) bus ();

   svutest_rsp_sink #(
      .W_PAYLOAD(32),
      .DEPTH(4),
      .W_COUNT(16),
      .SEED(16'hACE1)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus),
      .i_stall_en(stall_en),
      .i_expected_count(expected_count),
      .o_accepted_count(accepted_count),
      .o_level(level),
      .o_done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_chk           = 0;
      n_pass          = 0;
      rst             = 1'b0;
      stall_en        = 1'b0;
      expected_count  = '0;
      bus.req         = 1'b0;
      bus.req_payload = '0;
      bus.out_ready   = 1'b0;
      #2;
      chk("rst_rsp", bus.rsp, 1);
      chk("rst_valid", bus.out_valid, 0);
      chk("rst_acc", accepted_count, 0);
      chk("rst_level", level, 0);
      chk("rst_done", done, 0);
      #10;
      rst = 1'b1;
      step();

      // streaming: every beat visible one cycle after push
      bus.out_ready = 1'b1;
      bus.req       = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.req_payload = 32'h11 + i;
         chk("s_rsp", bus.rsp, 1);
         step();
         chk("s_valid", bus.out_valid, 1);
         chk("s_data", bus.out_payload, 64'h11 + i);
      end
      bus.req = 1'b0;
      step();
      chk("s_acc", accepted_count, 4);
      chk("s_level", level, 0);
      chk("s_empty", bus.out_valid, 0);

      // fill with drain blocked
      bus.out_ready = 1'b0;
      bus.req       = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.req_payload = 32'h1 + i;
         chk("f_rsp", bus.rsp, 1);
         step();
      end
      bus.req_payload = 32'h5;
      chk("f_full_rsp", bus.rsp, 0);
      chk("f_level", level, 4);
      chk("f_head", bus.out_payload, 1);

      // pop from full while req held: no push that cycle
      bus.out_ready = 1'b1;
      step();
      chk("fp_level", level, 3);
      chk("fp_rsp", bus.rsp, 1);
      chk("fp_acc", accepted_count, 8);
      chk("fp_data", bus.out_payload, 2);
      step();
      chk("fp_level2", level, 3);
      chk("fp_acc2", accepted_count, 9);
      chk("fp_data2", bus.out_payload, 3);
      bus.req = 1'b0;
      step();
      chk("d_data4", bus.out_payload, 4);
      step();
      chk("d_data5", bus.out_payload, 5);
      chk("d_level", level, 1);
      step();
      chk("d_empty", bus.out_valid, 0);
      chk("d_done0", done, 0);

      // two beats buffered, then async reset mid-cycle
      bus.out_ready   = 1'b0;
      bus.req         = 1'b1;
      bus.req_payload = 32'hA1;
      step();
      bus.req_payload = 32'hA2;
      step();
      bus.req = 1'b0;
      chk("r_level", level, 2);
      chk("r_acc", accepted_count, 11);
      #2;
      rst = 1'b0;
      #1;
      chk("ar_valid", bus.out_valid, 0);
      chk("ar_level", level, 0);
      chk("ar_acc", accepted_count, 0);
      chk("ar_done", done, 0);
      chk("ar_rsp", bus.rsp, 1);
      #2;
      rst = 1'b1;
      step();
      chk("ar_rsp2", bus.rsp, 1);
      chk("ar_valid2", bus.out_valid, 0);

      // done after three beats pushed and drained
      expected_count  = 16'd3;
      bus.out_ready   = 1'b1;
      bus.req         = 1'b1;
      bus.req_payload = 32'h31;
      step();
      bus.req_payload = 32'h32;
      step();
      bus.req_payload = 32'h33;
      step();
      bus.req = 1'b0;
      chk("dn_acc", accepted_count, 3);
      chk("dn_pend", done, 0);
      step();
      chk("dn_empty", bus.out_valid, 0);
      chk("dn_wait", done, 0);
      step();
      chk("dn_set", done, 1);
      bus.req         = 1'b1;
      bus.req_payload = 32'h44;
      step();
      bus.req = 1'b0;
      chk("dn_sticky", done, 1);
      chk("dn_acc4", accepted_count, 4);
      step();
      chk("dn_sticky2", done, 1);

`ifdef SVUTEST_RSP_SINK_STALL_EN
      begin
         logic [31:0] sb[$];
         logic [31:0] nxt;
         int          stalls;
         nxt      = 32'h1000;
         stalls   = 0;
         stall_en = 1'b1;
         bus.req  = 1'b1;
         for (int c = 0; c < 1000; c++) begin
            bus.req_payload = nxt;
            if (!bus.rsp) stalls++;
            if (bus.out_valid) begin
               chk("st_order", bus.out_payload, sb.pop_front());
            end
            if (bus.rsp) begin
               sb.push_back(nxt);
               nxt++;
            end
            step();
         end
         bus.req = 1'b0;
         for (int c = 0; c < 16 && sb.size() > 0; c++) begin
            if (bus.out_valid) begin
               chk("st_drain", bus.out_payload, sb.pop_front());
            end
            step();
         end
         chk("st_left", sb.size(), 0);
         chk("st_ratio", (stalls > 150) && (stalls < 350), 1);
         stall_en = 1'b0;
      end
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/svutest_rsp_sink.md
# svutest_rsp_sink

Downstream target for a request-payload-response channel: accepts beats on a req/req_payload/rsp handshake, buffers them in a FIFO, and re-presents them on a valid/ready drain port for a scoreboard or DUT. Sits directly downstream of the driver side of a request-payload-response link in a test bench. Applies backpressure via `rsp`, counts accepted beats and raises `done` once an expected number of beats has been accepted and drained.

## Interface
- `W_PAYLOAD`, 32, payload width in bits (≥1)
- `DEPTH`, 4, FIFO entries; power of two, ≥2
- `W_COUNT`, 16, width of beat counters
- `SEED`, 16'hACE1, LFSR reset value; must be non-zero (only used with stall feature)
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  asynchronous, active-low reset (asserted when 0)
- `req`  in  1  upstream request valid
- `req_payload`  in  W_PAYLOAD  upstream payload, sampled on transfer
- `rsp`  out  1  upstream accept; transfer when `req && rsp` at rising edge
- `out_valid`  out  1  drain-side valid
- `out_payload`  out  W_PAYLOAD  oldest buffered payload
- `out_ready`  in  1  drain-side ready; pop when `out_valid && out_ready`
- `stall_en`  in  1  enables pseudo-random backpressure
- `expected_count`  in  W_COUNT  beats required for `done`; sampled each cycle
- `accepted_count`  out  W_COUNT  total upstream transfers since reset
- `level`  out  $clog2(DEPTH)+1  current FIFO occupancy
- `done`  out  1  completion flag

## Operation
- FIFO: circular buffer, write/read pointers of $clog2(DEPTH)+1 bits (extra wrap bit); full = pointers equal except MSB, empty = pointers equal.
- Push on `req && rsp`: write `req_payload` at write pointer, increment write pointer, increment `accepted_count`.
- Pop on `out_valid && out_ready`: increment read pointer.
- `rsp = !full && !stall_q`; derived only from registered state, never from `req`.
- `out_valid = !empty`; `out_payload` = entry at read pointer.
- Simultaneous push and pop when neither full nor empty: both take effect, `level` unchanged.
- Full: `rsp` = 0 even if a pop occurs the same cycle; no pass-through.
- Empty: push lands the following cycle; no same-cycle bypass to `out_payload`.
- `accepted_count` saturates at all-ones; does not wrap.
- `done` register: set when `accepted_count >= expected_count`, FIFO empty, and `expected_count != 0`; stays set (sticky) until reset.
- Payload storage is not reset; only pointers, counters and flags are.

## Timing
- Reset values: `rsp` = 1 (FIFO empty, `stall_q` = 0), `out_valid` = 0, `out_payload` = don't-care, `accepted_count` = 0, `level` = 0, `done` = 0, LFSR = `SEED`.
- Push-to-`out_valid` latency: 1 cycle.
- `level` and `accepted_count` update the cycle after the transfer edge.
- `done` rises 1 cycle after the final condition becomes true.
- Reset mid-operation: all buffered beats discarded immediately (async); no beats are presented after deassertion until new pushes.
- Full throughput: one push and one pop per cycle sustained when `stall_en` = 0 and `out_ready` = 1.

## Configuration
- `SVUTEST_RSP_SINK_STALL_EN` defined: 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every cycle; `stall_q` registers `stall_en && (lfsr[1:0] == 2'b00)` (~25% stall). With the LFSR at `SEED` = 16'hACE1, `lfsr[1:0]` = 01, so the first post-reset stall decision is no-stall.
- Undefined: no LFSR, `stall_q` constant 0; `stall_en` and `SEED` are ignored; `rsp = !full`.

## Test plan
- Reset, `req` = 1, payloads 0x11..0x14, `out_ready` = 1 -> `rsp` = 1 every cycle, `out_payload` 0x11..0x14 each 1 cycle after push, `accepted_count` = 4.
- `out_ready` = 0, push 5 beats at `DEPTH` = 4 -> `rsp` drops after 4th transfer, `level` = 4, 5th beat held; raise `out_ready` -> 0x01..0x05 drained in order.
- Full FIFO with `out_ready` = 1 and `req` = 1 same cycle -> pop occurs, no push that cycle, `level` = 3, then `rsp` = 1 next cycle.
- `expected_count` = 3, push and drain 3 beats -> `done` = 1 exactly one cycle after the last pop; remains 1 on further traffic.
- Assert `rst` = 0 with `level` = 2 -> `out_valid`, `level`, `accepted_count`, `done` = 0 asynchronously; `rsp` = 1 after release.
- With macro defined, `stall_en` = 1, 1000 cycles `req` = 1, `out_ready` = 1 -> `rsp` low ~25% of cycles; all accepted beats drained in order, none lost or duplicated.
